// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// over a shared datapath, with a memory wait-state timeout and sticky fault.
module mips_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       Branch,
  output logic       BranchNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       fault
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTYPE  = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDI   = 4'd11,
    S_IWB    = 4'd12,
    S_FAULT  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // Counter holds the number of stall cycles already spent; the stall that
  // would make it MEM_TIMEOUT is the one that faults.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          cur;
  state_t          nxt;
  logic [TO_W-1:0] wait_cnt;
  logic            fault_q;
  logic            stalling;

  always_comb begin
    nxt      = cur;
    stalling = 1'b0;
    case (cur)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      nxt = S_RTYPE;
          OP_LW, OP_SW:  nxt = S_MEMADR;
          OP_BEQ, OP_BNE: nxt = S_BRANCH;
          OP_J:          nxt = S_JUMP;
          OP_ADDI:       nxt = S_ADDI;
          default:       nxt = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      nxt = S_MEMRD;
        else if (opcode == OP_SW) nxt = S_MEMWR;
        else                      nxt = S_FAULT;
      end
      S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  if (mem_ready) nxt = S_FETCH;
      S_RTYPE:  nxt = S_RWB;
      S_RWB:    nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_ADDI:   nxt = S_IWB;
      S_IWB:    nxt = S_FETCH;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_FAULT;
    endcase
    stalling = ((cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR)) && !mem_ready;
    if (stalling && (wait_cnt == TO_LAST)) nxt = S_FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= S_IDLE;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur)    wait_cnt <= '0;
      else if (stalling) wait_cnt <= wait_cnt + 1'b1;
      if (nxt == S_FAULT) fault_q <= 1'b1;
    end
  end

  // Decoded from the registered state (plus mem_ready in FETCH) so that an
  // asynchronous reset drops every write enable without waiting for a clock.
  always_comb begin
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    BranchNe = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSource = 2'b00;
    case (cur)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_RTYPE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSource = 2'b01;
        Branch   = (opcode == OP_BEQ);
        BranchNe = (opcode == OP_BNE);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_IWB: RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign state = cur;
  assign fault = fault_q;

endmodule
